// File: rtl/reservation_station_ooo_if.sv
// reservation_station_ooo_if: dispatch, wakeup, issue and status bundle for the reservation station
interface reservation_station_ooo_if #(
  parameter int XLEN     = 32,
  parameter int RS_DEPTH = 8,
  parameter int ROB_W    = 4,
  parameter int NUM_CDB  = 2,
  parameter int OP_W     = 5
);
  localparam int CW = $clog2(RS_DEPTH + 1);
  logic                    rdy;
  logic                    flush;
  logic                    disp_valid;
  logic [OP_W-1:0]         disp_op;
  logic [ROB_W-1:0]        disp_id;
  logic                    disp_q1_wait;
  logic [ROB_W-1:0]        disp_q1;
  logic [XLEN-1:0]         disp_v1;
  logic                    disp_q2_wait;
  logic [ROB_W-1:0]        disp_q2;
  logic [XLEN-1:0]         disp_v2;
  logic [ROB_W-1:0]        rob_head;
  logic [NUM_CDB-1:0]      cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_id;
  logic [NUM_CDB*XLEN-1:0] cdb_val;
  logic                    rs_full;
  logic [CW-1:0]           rs_count;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [OP_W-1:0]         iss_op;
  logic [XLEN-1:0]         iss_val1;
  logic [XLEN-1:0]         iss_val2;
  logic [ROB_W-1:0]        iss_id;
  modport master (
    output rdy, flush, disp_valid, disp_op, disp_id, disp_q1_wait, disp_q1, disp_v1,
           disp_q2_wait, disp_q2, disp_v2, rob_head, cdb_valid, cdb_id, cdb_val, iss_ready,
    input  rs_full, rs_count, iss_valid, iss_op, iss_val1, iss_val2, iss_id
  );
  modport slave (
    input  rdy, flush, disp_valid, disp_op, disp_id, disp_q1_wait, disp_q1, disp_v1,
           disp_q2_wait, disp_q2, disp_v2, rob_head, cdb_valid, cdb_id, cdb_val, iss_ready,
    output rs_full, rs_count, iss_valid, iss_op, iss_val1, iss_val2, iss_id
  );
endinterface

// File: rtl/reservation_station_ooo.sv
// reservation_station_ooo: age-ordered ALU reservation station with CDB wakeup and registered issue
module reservation_station_ooo #(
  parameter int XLEN     = 32,
  parameter int RS_DEPTH = 8,
  parameter int ROB_W    = 4,
  parameter int NUM_CDB  = 2,
  parameter int OP_W     = 5
) (
  input logic clk,
  input logic rst,
  reservation_station_ooo_if.slave bus
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = $clog2(RS_DEPTH + 1);
  logic             vld_q [RS_DEPTH];
  logic [OP_W-1:0]  op_q  [RS_DEPTH];
  logic [ROB_W-1:0] id_q  [RS_DEPTH];
  logic [ROB_W-1:0] t1_q  [RS_DEPTH];
  logic [ROB_W-1:0] t2_q  [RS_DEPTH];
  logic             r1_q  [RS_DEPTH];
  logic             r2_q  [RS_DEPTH];
  logic [XLEN-1:0]  v1_q  [RS_DEPTH];
  logic [XLEN-1:0]  v2_q  [RS_DEPTH];
  logic             iss_valid_q;
  logic [OP_W-1:0]  iss_op_q;
  logic [XLEN-1:0]  iss_val1_q;
  logic [XLEN-1:0]  iss_val2_q;
  logic [ROB_W-1:0] iss_id_q;
  logic [XLEN:0]    wk1 [RS_DEPTH];
  logic [XLEN:0]    wk2 [RS_DEPTH];
  logic [XLEN:0]    byp1;
  logic [XLEN:0]    byp2;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    sel_idx;
  logic [ROB_W-1:0] best_age;
  logic             any_rdy;
  logic             full;
  logic             disp_ok;
  logic             load;
  logic             issue;

  // {hit, value} of the lowest-numbered broadcast channel carrying tag
  function automatic logic [XLEN:0] snoop(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*ROB_W-1:0] cid,
    input logic [NUM_CDB*XLEN-1:0]  cval
  );
    logic [XLEN:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (cv[k] && cid[k*ROB_W +: ROB_W] == tag) r = {1'b1, cval[k*XLEN +: XLEN]};
    return r;
  endfunction

  // Occupancy, lowest free slot and oldest ready entry, all from registered state
  always_comb begin
    logic [ROB_W-1:0] age;
    age      = '0;
    cnt      = '0;
    free_idx = '0;
    sel_idx  = '0;
    best_age = '0;
    any_rdy  = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!vld_q[i]) free_idx = IW'(i);
    for (int i = 0; i < RS_DEPTH; i++) begin
      cnt = cnt + CW'(vld_q[i]);
      age = id_q[i] - bus.rob_head;
      if (vld_q[i] && r1_q[i] && r2_q[i] && (!any_rdy || age < best_age)) begin
        any_rdy  = 1'b1;
        sel_idx  = IW'(i);
        best_age = age;
      end
    end
  end

  // Per-entry wakeup matches and same-cycle dispatch bypass
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wk1[i] = snoop(t1_q[i], bus.cdb_valid, bus.cdb_id, bus.cdb_val);
      wk2[i] = snoop(t2_q[i], bus.cdb_valid, bus.cdb_id, bus.cdb_val);
    end
    byp1 = snoop(bus.disp_q1, bus.cdb_valid, bus.cdb_id, bus.cdb_val);
    byp2 = snoop(bus.disp_q2, bus.cdb_valid, bus.cdb_id, bus.cdb_val);
  end

  assign full    = cnt == CW'(RS_DEPTH);
  assign disp_ok = bus.disp_valid && !full;
  assign load    = !iss_valid_q || bus.iss_ready;
  assign issue   = load && any_rdy;

  // Entry array and issue register update: rst > flush > wakeup/issue/dispatch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) vld_q[i] <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_val1_q  <= '0;
      iss_val2_q  <= '0;
      iss_id_q    <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        for (int i = 0; i < RS_DEPTH; i++) vld_q[i] <= 1'b0;
        iss_valid_q <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (vld_q[i] && !r1_q[i] && wk1[i][XLEN]) begin
            r1_q[i] <= 1'b1;
            v1_q[i] <= wk1[i][XLEN-1:0];
          end
          if (vld_q[i] && !r2_q[i] && wk2[i][XLEN]) begin
            r2_q[i] <= 1'b1;
            v2_q[i] <= wk2[i][XLEN-1:0];
          end
        end
        if (issue) vld_q[sel_idx] <= 1'b0;
        if (disp_ok) begin
          vld_q[free_idx] <= 1'b1;
          op_q[free_idx]  <= bus.disp_op;
          id_q[free_idx]  <= bus.disp_id;
          t1_q[free_idx]  <= bus.disp_q1;
          t2_q[free_idx]  <= bus.disp_q2;
          r1_q[free_idx]  <= !bus.disp_q1_wait || byp1[XLEN];
          r2_q[free_idx]  <= !bus.disp_q2_wait || byp2[XLEN];
          v1_q[free_idx]  <= bus.disp_q1_wait ? byp1[XLEN-1:0] : bus.disp_v1;
          v2_q[free_idx]  <= bus.disp_q2_wait ? byp2[XLEN-1:0] : bus.disp_v2;
        end
        if (load) iss_valid_q <= any_rdy;
        if (issue) begin
          iss_op_q   <= op_q[sel_idx];
          iss_val1_q <= v1_q[sel_idx];
          iss_val2_q <= v2_q[sel_idx];
          iss_id_q   <= id_q[sel_idx];
        end
      end
    end
  end

  assign bus.rs_full   = full;
  assign bus.rs_count  = cnt;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_val1  = iss_val1_q;
  assign bus.iss_val2  = iss_val2_q;
  assign bus.iss_id    = iss_id_q;
endmodule

// File: tb/tb_reservation_station_ooo.sv
// tb_reservation_station_ooo: directed vector table plus hand sequences for full, hold and flush
module tb_reservation_station_ooo;
  logic clk;
  logic rst;
  int checks;
  int errors;

  reservation_station_ooo_if #(.XLEN(32), .RS_DEPTH(8), .ROB_W(4), .NUM_CDB(2), .OP_W(5)) bus ();

  reservation_station_ooo #(.XLEN(32), .RS_DEPTH(8), .ROB_W(4), .NUM_CDB(2), .OP_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  op;
    logic [3:0]  id;
    logic        w1;
    logic [3:0]  q1;
    logic [31:0] v1;
    logic        w2;
    logic [3:0]  q2;
    logic [31:0] v2;
    logic [3:0]  head;
    logic [1:0]  cv;
    logic [7:0]  cid;
    logic [63:0] cval;
    logic        ir;
    logic        e_iv;
    logic [4:0]  e_op;
    logic [3:0]  e_id;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid   = 1'b0;
    bus.disp_q1_wait = 1'b0;
    bus.disp_q2_wait = 1'b0;
    bus.cdb_valid    = 2'b00;
    bus.flush        = 1'b0;
  endtask

  task automatic disp(input logic [3:0] id);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = {1'b0, id};
    bus.disp_id      = id;
    bus.disp_q1_wait = 1'b0;
    bus.disp_q2_wait = 1'b0;
    bus.disp_v1      = 32'd100 + 32'(id);
    bus.disp_v2      = 32'(id);
  endtask

  task automatic chk_iss(input string nm, input logic [3:0] id, input logic [31:0] v1);
    chk({nm, "_iv"}, 32'(bus.iss_valid), 32'd1);
    chk({nm, "_id"}, 32'(bus.iss_id), 32'(id));
    chk({nm, "_v1"}, bus.iss_val1, v1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // dv op id w1 q1 v1 w2 q2 v2 head cv cid cval ir | e_iv e_op e_id e_v1 e_v2 e_cnt
    vecs[0]  = '{1'b1, 5'd1, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd0, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd1};
    vecs[1]  = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b1, 5'd1, 4'd3, 32'd5, 32'd7, 4'd0};
    vecs[2]  = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[3]  = '{1'b1, 5'd2, 4'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd2, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd1};
    vecs[4]  = '{1'b1, 5'd3, 4'd15, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 4'd14, 2'b01, 8'h00, 64'h9, 1'b1,
                 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd2};
    vecs[5]  = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b1, 5'd3, 4'd15, 32'd3, 32'd4, 4'd1};
    vecs[6]  = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b1, 5'd2, 4'd1, 32'd9, 32'd2, 4'd0};
    vecs[7]  = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0};
    vecs[8]  = '{1'b1, 5'd4, 4'd2, 1'b1, 4'd6, 32'h1111, 1'b0, 4'd0, 32'h10, 4'd14, 2'b11, 8'h65,
                 64'h0000DEAD_0000BEEF, 1'b1, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd1};
    vecs[9]  = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b1, 5'd4, 4'd2, 32'hDEAD, 32'h10, 4'd0};
    vecs[10] = '{1'b1, 5'd5, 4'd4, 1'b0, 4'd0, 32'd1, 1'b1, 4'd7, 32'd0, 4'd14, 2'b11, 8'h77,
                 64'h00000222_00000111, 1'b1, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd1};
    vecs[11] = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b1, 5'd5, 4'd4, 32'd1, 32'h111, 4'd0};
    vecs[12] = '{1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd14, 2'b00, 8'h00, 64'h0, 1'b1,
                 1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0};

    rst = 1'b1;
    bus.rdy = 1'b0;
    bus.disp_op = '0;
    bus.disp_id = '0;
    bus.disp_q1 = '0;
    bus.disp_q2 = '0;
    bus.disp_v1 = '0;
    bus.disp_v2 = '0;
    bus.rob_head = '0;
    bus.cdb_id = '0;
    bus.cdb_val = '0;
    bus.iss_ready = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_iv", 32'(bus.iss_valid), 32'd0);
    chk("rst_cnt", 32'(bus.rs_count), 32'd0);
    chk("rst_full", 32'(bus.rs_full), 32'd0);
    chk("rst_id", 32'(bus.iss_id), 32'd0);
    chk("rst_v1", bus.iss_val1, 32'd0);
    rst = 1'b0;
    bus.rdy = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.disp_valid   = vecs[i].dv;
      bus.disp_op      = vecs[i].op;
      bus.disp_id      = vecs[i].id;
      bus.disp_q1_wait = vecs[i].w1;
      bus.disp_q1      = vecs[i].q1;
      bus.disp_v1      = vecs[i].v1;
      bus.disp_q2_wait = vecs[i].w2;
      bus.disp_q2      = vecs[i].q2;
      bus.disp_v2      = vecs[i].v2;
      bus.rob_head     = vecs[i].head;
      bus.cdb_valid    = vecs[i].cv;
      bus.cdb_id       = vecs[i].cid;
      bus.cdb_val      = vecs[i].cval;
      bus.iss_ready    = vecs[i].ir;
      tick();
      chk($sformatf("v%0d_iv", i), 32'(bus.iss_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d_cnt", i), 32'(bus.rs_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_full", i), 32'(bus.rs_full), 32'd0);
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_id", i), 32'(bus.iss_id), 32'(vecs[i].e_id));
        chk($sformatf("v%0d_op", i), 32'(bus.iss_op), 32'(vecs[i].e_op));
        chk($sformatf("v%0d_v1", i), bus.iss_val1, vecs[i].e_v1);
        chk($sformatf("v%0d_v2", i), bus.iss_val2, vecs[i].e_v2);
      end
    end

    idle();
    bus.rob_head = 4'd0;
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      disp(4'(i));
      tick();
    end
    chk("full_flag", 32'(bus.rs_full), 32'd1);
    chk("full_cnt", 32'(bus.rs_count), 32'd8);
    chk_iss("full_hold", 4'd0, 32'd100);
    bus.rdy = 1'b0;
    bus.iss_ready = 1'b1;
    tick();
    chk("rdy0_cnt", 32'(bus.rs_count), 32'd8);
    chk_iss("rdy0_hold", 4'd0, 32'd100);
    bus.rdy = 1'b1;
    tick();
    chk_iss("drain1", 4'd1, 32'd101);
    chk("drain1_cnt", 32'(bus.rs_count), 32'd7);
    chk("drain1_full", 32'(bus.rs_full), 32'd0);
    idle();
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk_iss($sformatf("drain%0d", i), 4'(i), 32'd100 + 32'(i));
      chk($sformatf("drain%0d_cnt", i), 32'(bus.rs_count), 32'(8 - i));
    end
    tick();
    chk("drained_iv", 32'(bus.iss_valid), 32'd0);
    chk("drained_cnt", 32'(bus.rs_count), 32'd0);

    bus.iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(4'(i));
      tick();
    end
    chk("pre_flush_cnt", 32'(bus.rs_count), 32'd5);
    chk_iss("pre_flush", 4'd0, 32'd100);
    disp(4'd10);
    bus.flush = 1'b1;
    tick();
    chk("flush_cnt", 32'(bus.rs_count), 32'd0);
    chk("flush_iv", 32'(bus.iss_valid), 32'd0);
    idle();
    bus.iss_ready = 1'b1;
    tick();
    tick();
    chk("post_flush_iv", 32'(bus.iss_valid), 32'd0);
    chk("post_flush_cnt", 32'(bus.rs_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
